tt_gate_array_dbnc: RTL

//  Parametrised successor to the single-bit inverter tile: CH independent channels, each with an

---
 rtl/tt_gate_pkg.sv | 11 +
 rtl/tt_dbnc_ch.sv | 81 ++++++++
 rtl/tt_gate_array_dbnc.sv | 56 +++++
 3 files changed

// File: rtl/tt_gate_pkg.sv
// Shared definitions for the debounced gate array: output-stage mode encoding.
package tt_gate_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_NOT    = 2'b00;
  localparam mode_t MODE_BUF    = 2'b01;
  localparam mode_t MODE_HOLD   = 2'b10;
  localparam mode_t MODE_TOGGLE = 2'b11;

endpackage

// File: rtl/tt_dbnc_ch.sv
// One channel: input synchroniser, debounce filter, mode register and registered output stage.
module tt_dbnc_ch
  import tt_gate_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 4,
  parameter int unsigned DB_CYCLES   = 10
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_raw,
  input  logic  mode_we,
  input  mode_t mode_wdata,
  output logic  out,
  output logic  edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q;
  logic                   stable_q;
  logic                   chg_q;
  logic                   tog_q;
  mode_t                  mode_q;

  logic  s;
  logic  db_hit;
  logic  rise;
  logic  tog_nxt;
  logic  out_nxt;
  mode_t mode_eff;

  assign s      = sync_q[SYNC_STAGES-1];
  assign db_hit = (s != stable_q) && (cnt_q == DB_W'(DB_CYCLES - 1));
  assign rise   = chg_q & stable_q;

  // A mode written this edge already decides the output this edge.
  always_comb begin
    mode_eff = mode_we ? mode_wdata : mode_q;
    tog_nxt  = tog_q;
    out_nxt  = out;
    case (mode_eff)
      MODE_NOT:  out_nxt = ~stable_q;
      MODE_BUF:  out_nxt = stable_q;
      MODE_HOLD: out_nxt = out;
      default: begin
        // Entering TOGGLE seeds the toggle state from the visible output.
        tog_nxt = ((mode_q == MODE_TOGGLE) ? tog_q : out) ^ rise;
        out_nxt = tog_nxt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
      chg_q      <= 1'b0;
      tog_q      <= 1'b0;
      mode_q     <= MODE_NOT;
      out        <= 1'b1;
      edge_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
      if (s == stable_q) begin
        cnt_q <= '0;
      end else if (db_hit) begin
        stable_q <= s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
      chg_q      <= db_hit;
      edge_pulse <= chg_q;
      tog_q      <= tog_nxt;
      out        <= out_nxt;
      if (mode_we) mode_q <= mode_wdata;
    end
  end

endmodule

// File: rtl/tt_gate_array_dbnc.sv
// CH debounced gate channels behind a valid/ready per-channel mode config port.
module tt_gate_array_dbnc
  import tt_gate_pkg::*;
#(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 4,
  parameter int unsigned DB_CYCLES   = 10,
  localparam int unsigned CW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in_raw,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_ch,
  input  mode_t         cfg_mode,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic [CH-1:0] out,
  output logic [CH-1:0] edge_pulse
);

  logic accept;
  logic in_range;

  assign accept   = cfg_valid & cfg_ready;
  assign in_range = 32'(cfg_ch) < CH;

  // Ready drops for one cycle after every accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
      cfg_err   <= accept & ~in_range;
    end
  end

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    tt_dbnc_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W),
      .DB_CYCLES   (DB_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .in_raw     (in_raw[i]),
      .mode_we    (accept && (cfg_ch == CW'(i))),
      .mode_wdata (cfg_mode),
      .out        (out[i]),
      .edge_pulse (edge_pulse[i])
    );
  end

endmodule
